// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Holds funct3 encodings, the FSM state encoding and the funct3 legality check.
package lsu_pkg;

    localparam int REG_BUS = 32;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    function automatic logic funct3_legal(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Bundle of the EXU request, WBU response and data-memory port of the LSU.
// The LSU uses the slave view; whatever drives it (EXU/WBU/memory model) uses master.
interface lsu_if;
    import lsu_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic               in_ren;
    logic               in_wen;
    logic [2:0]         in_funct3;
    logic [REG_BUS-1:0] in_addr;
    logic [REG_BUS-1:0] in_wdata;
    logic               out_valid;
    logic               out_ready;
    logic [REG_BUS-1:0] out_rdata;
    logic               out_err;
    logic               mem_valid;
    logic               mem_wen;
    logic [7:0]         mem_wmask;
    logic [REG_BUS-1:0] mem_waddr;
    logic [REG_BUS-1:0] mem_wdata;
    logic [REG_BUS-1:0] mem_raddr;
    logic [REG_BUS-1:0] mem_rdata;

    modport slave (
        input  in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, out_ready, mem_rdata,
        output in_ready, out_valid, out_rdata, out_err,
        output mem_valid, mem_wen, mem_wmask, mem_waddr, mem_wdata, mem_raddr
    );

    modport master (
        output in_valid, in_ren, in_wen, in_funct3, in_addr, in_wdata, out_ready, mem_rdata,
        input  in_ready, out_valid, out_rdata, out_err,
        input  mem_valid, mem_wen, mem_wmask, mem_waddr, mem_wdata, mem_raddr
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data shifting, load extraction and misalignment detect.
// Purely combinational; funct3[2] selects zero-extension on loads.
module lsu_align
    import lsu_pkg::*;
(
    input  logic               is_store_i,
    input  logic [2:0]         funct3_i,
    input  logic [1:0]         off_i,
    input  logic [REG_BUS-1:0] wdata_i,
    input  logic [REG_BUS-1:0] rdata_i,
    output logic [7:0]         wmask_o,
    output logic [REG_BUS-1:0] wdata_o,
    output logic [REG_BUS-1:0] rdata_o,
    output logic               misalign_o
);

    logic [4:0]         sh_amt;
    logic [REG_BUS-1:0] rd_sh;

    assign sh_amt = {off_i, 3'b000};
    assign rd_sh  = rdata_i >> sh_amt;

    always_comb begin
        wmask_o    = '0;
        wdata_o    = '0;
        rdata_o    = '0;
        misalign_o = 1'b0;
        unique case (funct3_i[1:0])
            2'b00: begin
                if (is_store_i) begin
                    wmask_o = 8'h01 << off_i;
                    wdata_o = {24'b0, wdata_i[7:0]} << sh_amt;
                end
                rdata_o = funct3_i[2] ? {24'b0, rd_sh[7:0]} : {{24{rd_sh[7]}}, rd_sh[7:0]};
            end
            2'b01: begin
                misalign_o = off_i[0];
                if (is_store_i) begin
                    wmask_o = 8'h03 << off_i;
                    wdata_o = {16'b0, wdata_i[15:0]} << sh_amt;
                end
                rdata_o = funct3_i[2] ? {16'b0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
            end
            2'b10: begin
                misalign_o = (off_i != 2'b00);
                if (is_store_i) begin
                    wmask_o = 8'h0F;
                    wdata_o = wdata_i;
                end
                rdata_o = rdata_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: accepts one op from EXU, drives the data-memory port for
// MEM_LATENCY cycles, then returns extended load data (or an error) to WBU.
module lsu
    import lsu_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic  clk,
    input  logic  rst,
    lsu_if.slave  bus
);

    localparam int CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    lsu_state_e         state_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ren_q, wen_q;
    logic [2:0]         funct3_q;
    logic [1:0]         off_q;
    logic               in_ready_q, out_valid_q, out_err_q;
    logic [REG_BUS-1:0] out_rdata_q;
    logic               mem_valid_q, mem_wen_q;
    logic [7:0]         mem_wmask_q;
    logic [REG_BUS-1:0] mem_addr_q, mem_wdata_q;

    logic [2:0]         al_funct3;
    logic [1:0]         al_off;
    logic [7:0]         al_wmask;
    logic [REG_BUS-1:0] al_wdata, al_rdata;
    logic               al_misalign;
    logic               req_fire, req_legal;

    // In IDLE the aligner sees the incoming op; afterwards it sees the latched one.
    assign al_funct3 = (state_q == ST_IDLE) ? bus.in_funct3 : funct3_q;
    assign al_off    = (state_q == ST_IDLE) ? bus.in_addr[1:0] : off_q;
    assign cnt_d     = cnt_q + 1'b1;
    assign req_fire  = bus.in_valid && in_ready_q;
    assign req_legal = funct3_legal(bus.in_wen, bus.in_funct3) && !al_misalign;

    lsu_align u_align (
        .is_store_i (bus.in_wen),
        .funct3_i   (al_funct3),
        .off_i      (al_off),
        .wdata_i    (bus.in_wdata),
        .rdata_i    (bus.mem_rdata),
        .wmask_o    (al_wmask),
        .wdata_o    (al_wdata),
        .rdata_o    (al_rdata),
        .misalign_o (al_misalign)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            funct3_q    <= '0;
            off_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
            out_rdata_q <= '0;
            mem_valid_q <= 1'b0;
            mem_wen_q   <= 1'b0;
            mem_wmask_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (req_fire) begin
                        ren_q      <= bus.in_ren;
                        wen_q      <= bus.in_wen;
                        funct3_q   <= bus.in_funct3;
                        off_q      <= bus.in_addr[1:0];
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        if (!bus.in_wen && !bus.in_ren) begin
                            state_q     <= ST_RESP;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b0;
                            out_rdata_q <= '0;
                        end else if (!req_legal) begin
                            state_q     <= ST_RESP;
                            out_valid_q <= 1'b1;
                            out_err_q   <= 1'b1;
                            out_rdata_q <= '0;
                        end else begin
                            state_q     <= ST_ACCESS;
                            mem_valid_q <= 1'b1;
                            mem_wen_q   <= bus.in_wen && (CNT_LAST == '0);
                            mem_wmask_q <= al_wmask;
                            mem_wdata_q <= al_wdata;
                            mem_addr_q  <= {bus.in_addr[31:2], 2'b00};
                        end
                    end
                end
                ST_ACCESS: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_RESP;
                        out_valid_q <= 1'b1;
                        out_err_q   <= 1'b0;
                        out_rdata_q <= (ren_q && !wen_q) ? al_rdata : '0;
                        mem_valid_q <= 1'b0;
                        mem_wen_q   <= 1'b0;
                        mem_wmask_q <= '0;
                        mem_wdata_q <= '0;
                        mem_addr_q  <= '0;
                    end else begin
                        cnt_q     <= cnt_d;
                        mem_wen_q <= wen_q && (cnt_d == CNT_LAST);
                    end
                end
                ST_RESP: begin
                    if (bus.out_ready) begin
                        state_q     <= ST_IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_rdata = out_rdata_q;
    assign bus.out_err   = out_err_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_wen   = mem_wen_q;
    assign bus.mem_wmask = mem_wmask_q;
    assign bus.mem_waddr = mem_addr_q;
    assign bus.mem_raddr = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: one instance with MEM_LATENCY=1 and one with 3,
// selected per op by sel; expected values are hand-computed constants.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        in_valid = 1'b0, in_ren = 1'b0, in_wen = 1'b0, out_ready = 1'b0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_addr = '0, in_wdata = '0, mem_rdata = '0;

    int n_checks = 0;
    int n_errors = 0;

    lsu_if if1 ();
    lsu_if if3 ();

    assign if1.in_valid  = in_valid & ~sel;
    assign if3.in_valid  = in_valid & sel;
    assign if1.out_ready = out_ready & ~sel;
    assign if3.out_ready = out_ready & sel;
    assign if1.in_ren = in_ren;       assign if3.in_ren = in_ren;
    assign if1.in_wen = in_wen;       assign if3.in_wen = in_wen;
    assign if1.in_funct3 = in_funct3; assign if3.in_funct3 = in_funct3;
    assign if1.in_addr = in_addr;     assign if3.in_addr = in_addr;
    assign if1.in_wdata = in_wdata;   assign if3.in_wdata = in_wdata;
    assign if1.mem_rdata = mem_rdata; assign if3.mem_rdata = mem_rdata;

    lsu #(.MEM_LATENCY(1)) u_lsu1 (.clk(clk), .rst(rst), .bus(if1.slave));
    lsu #(.MEM_LATENCY(3)) u_lsu3 (.clk(clk), .rst(rst), .bus(if3.slave));

    wire        o_in_ready  = sel ? if3.in_ready  : if1.in_ready;
    wire        o_out_valid = sel ? if3.out_valid : if1.out_valid;
    wire [31:0] o_out_rdata = sel ? if3.out_rdata : if1.out_rdata;
    wire        o_out_err   = sel ? if3.out_err   : if1.out_err;
    wire        o_mem_valid = sel ? if3.mem_valid : if1.mem_valid;
    wire        o_mem_wen   = sel ? if3.mem_wen   : if1.mem_wen;
    wire [7:0]  o_mem_wmask = sel ? if3.mem_wmask : if1.mem_wmask;
    wire [31:0] o_mem_waddr = sel ? if3.mem_waddr : if1.mem_waddr;
    wire [31:0] o_mem_raddr = sel ? if3.mem_raddr : if1.mem_raddr;
    wire [31:0] o_mem_wdata = sel ? if3.mem_wdata : if1.mem_wdata;

    always #5 clk = ~clk;

    int          lat, nv, nw, wen_at;
    logic [7:0]  cap_wmask;
    logic [31:0] cap_waddr, cap_raddr, cap_wdata, r_rdata;
    logic        r_err;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, act, exp);
        end
    endtask

    // Called at posedge+1 with the selected DUT idle; returns once out_valid is seen.
    task automatic run_op(input logic s, input logic ren, input logic wen, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rd);
        sel = s; in_ren = ren; in_wen = wen; in_funct3 = f3;
        in_addr = addr; in_wdata = wd; mem_rdata = rd; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0; nv = 0; nw = 0; wen_at = 0;
        cap_wmask = '0; cap_waddr = '0; cap_raddr = '0; cap_wdata = '0;
        while (!o_out_valid && lat < 20) begin
            if (o_mem_valid) begin
                nv++;
                cap_wmask = o_mem_wmask; cap_waddr = o_mem_waddr;
                cap_raddr = o_mem_raddr; cap_wdata = o_mem_wdata;
            end
            if (o_mem_wen) begin
                nw++;
                wen_at = lat + 1;
            end
            @(posedge clk); #1;
            lat++;
        end
        chk("resp_seen", {31'b0, o_out_valid}, 32'd1);
        r_rdata = o_out_rdata;
        r_err   = o_out_err;
    endtask

    task automatic finish_resp(input int hold, input logic [31:0] exp_rd, input logic exp_err);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_valid", {31'b0, o_out_valid}, 32'd1);
            chk("hold_rdata", o_out_rdata, exp_rd);
            chk("hold_err", {31'b0, o_out_err}, {31'b0, exp_err});
            chk("hold_in_ready", {31'b0, o_in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("post_in_ready", {31'b0, o_in_ready}, 32'd1);
        chk("post_out_valid", {31'b0, o_out_valid}, 32'd0);
    endtask

    task automatic check_load(input string tag, input logic s, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] rd,
                              input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        run_op(s, 1'b1, 1'b0, f3, addr, 32'h0, rd);
        chk({tag, "_rdata"}, r_rdata, exp_rd);
        chk({tag, "_err"}, {31'b0, r_err}, {31'b0, exp_err});
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_nvalid"}, nv, exp_lat);
        chk({tag, "_nwen"}, nw, 0);
        chk({tag, "_wmask"}, {24'b0, cap_wmask}, 32'h0);
        finish_resp(0, exp_rd, exp_err);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_in_ready", {31'b0, o_in_ready}, 32'd1);
        chk("rst_out_valid", {31'b0, o_out_valid}, 32'd0);
        chk("rst_out_rdata", o_out_rdata, 32'h0);
        chk("rst_mem_valid", {31'b0, o_mem_valid}, 32'd0);
        chk("rst_mem_wmask", {24'b0, o_mem_wmask}, 32'h0);
        chk("rst_mem_waddr", o_mem_waddr, 32'h0);

        // SW, latency 1
        run_op(1'b0, 1'b0, 1'b1, 3'b010, 32'h8000_0004, 32'hDEAD_BEEF, 32'h0);
        chk("sw_waddr", cap_waddr, 32'h8000_0004);
        chk("sw_raddr", cap_raddr, 32'h8000_0004);
        chk("sw_wmask", {24'b0, cap_wmask}, 32'h0F);
        chk("sw_wdata", cap_wdata, 32'hDEAD_BEEF);
        chk("sw_nwen", nw, 1);
        chk("sw_lat", lat, 1);
        chk("sw_rdata", r_rdata, 32'h0);
        chk("sw_err", {31'b0, r_err}, 32'd0);
        chk("sw_resp_mem_valid", {31'b0, o_mem_valid}, 32'd0);
        finish_resp(0, 32'h0, 1'b0);

        // SB to top lane
        run_op(1'b0, 1'b0, 1'b1, 3'b000, 32'h8000_0003, 32'h0000_00AB, 32'h0);
        chk("sb_wmask", {24'b0, cap_wmask}, 32'h08);
        chk("sb_wdata", cap_wdata, 32'hAB00_0000);
        chk("sb_waddr", cap_waddr, 32'h8000_0000);
        chk("sb_nwen", nw, 1);
        finish_resp(0, 32'h0, 1'b0);

        // SH to upper half
        run_op(1'b0, 1'b0, 1'b1, 3'b001, 32'h8000_0002, 32'hCAFE_5A5A, 32'h0);
        chk("sh2_wmask", {24'b0, cap_wmask}, 32'h0C);
        chk("sh2_wdata", cap_wdata, 32'h5A5A_0000);
        finish_resp(0, 32'h0, 1'b0);

        check_load("lb",  1'b0, 3'b000, 32'h8000_0003, 32'hAB00_0000, 32'hFFFF_FFAB, 1'b0, 1);
        check_load("lbu", 1'b0, 3'b100, 32'h8000_0003, 32'hAB00_0000, 32'h0000_00AB, 1'b0, 1);
        check_load("lb1", 1'b0, 3'b000, 32'h8000_0001, 32'h0000_7F00, 32'h0000_007F, 1'b0, 1);
        check_load("lh",  1'b0, 3'b001, 32'h8000_0002, 32'h8001_1234, 32'hFFFF_8001, 1'b0, 1);
        check_load("lhu", 1'b0, 3'b101, 32'h8000_0002, 32'h8001_1234, 32'h0000_8001, 1'b0, 1);
        check_load("lh0", 1'b0, 3'b001, 32'h8000_0000, 32'h8001_1234, 32'h0000_1234, 1'b0, 1);
        check_load("lw_mis", 1'b0, 3'b010, 32'h8000_0002, 32'h1111_1111, 32'h0, 1'b1, 0);
        check_load("lh_mis", 1'b0, 3'b001, 32'h8000_0001, 32'h1111_1111, 32'h0, 1'b1, 0);
        check_load("ld_f3",  1'b0, 3'b011, 32'h8000_0000, 32'h1111_1111, 32'h0, 1'b1, 0);

        // Store with a load-only funct3 is illegal
        run_op(1'b0, 1'b0, 1'b1, 3'b100, 32'h8000_0000, 32'h1234_5678, 32'h0);
        chk("st_f3_err", {31'b0, r_err}, 32'd1);
        chk("st_f3_nvalid", nv, 0);
        finish_resp(0, 32'h0, 1'b1);

        // Neither load nor store
        run_op(1'b0, 1'b0, 1'b0, 3'b111, 32'h8000_0001, 32'h0, 32'hFFFF_FFFF);
        chk("nop_err", {31'b0, r_err}, 32'd0);
        chk("nop_rdata", r_rdata, 32'h0);
        chk("nop_nvalid", nv, 0);
        finish_resp(0, 32'h0, 1'b0);

        // Latency 3 store with WBU back-pressure
        run_op(1'b1, 1'b0, 1'b1, 3'b001, 32'h8000_0000, 32'h1234_5678, 32'h0);
        chk("l3_sh_nvalid", nv, 3);
        chk("l3_sh_nwen", nw, 1);
        chk("l3_sh_wen_at", wen_at, 3);
        chk("l3_sh_lat", lat, 3);
        chk("l3_sh_wmask", {24'b0, cap_wmask}, 32'h03);
        chk("l3_sh_wdata", cap_wdata, 32'h0000_5678);
        finish_resp(4, 32'h0, 1'b0);

        check_load("l3_lw", 1'b1, 3'b010, 32'h8000_0008, 32'h1234_5678, 32'h1234_5678, 1'b0, 3);

        // Reset during the second ACCESS cycle of a latency-3 store
        sel = 1'b1; in_ren = 1'b0; in_wen = 1'b1; in_funct3 = 3'b010;
        in_addr = 32'h8000_0010; in_wdata = 32'h5555_AAAA; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("rst_acc1_valid", {31'b0, o_mem_valid}, 32'd1);
        @(posedge clk); #1;
        chk("rst_acc2_valid", {31'b0, o_mem_valid}, 32'd1);
        chk("rst_acc2_wen", {31'b0, o_mem_wen}, 32'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_valid", {31'b0, o_mem_valid}, 32'd0);
        chk("rst_async_wen", {31'b0, o_mem_wen}, 32'd0);
        chk("rst_async_in_ready", {31'b0, o_in_ready}, 32'd1);
        chk("rst_async_out_valid", {31'b0, o_out_valid}, 32'd0);
        nw = 0; nv = 0;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (o_mem_wen) nw++;
            if (o_mem_valid) nv++;
            @(posedge clk); #1;
        end
        chk("rst_after_nwen", nw, 0);
        chk("rst_after_nvalid", nv, 0);
        chk("rst_after_in_ready", {31'b0, o_in_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsu.md
Name: lsu

Overview:
- Load/store unit of the RV32E NPC; sits directly upstream of the DPI data-memory block and drives its valid/wen/wmask/waddr/wdata/raddr inputs while consuming its rdata.
- Accepts one memory op at a time from EXU via valid/ready and word-aligns the address.
- Builds the byte mask and shifted store data, holds the request for a configurable latency, then extracts/sign-extends load data and hands it to WBU via valid/ready.

Parameters:
- MEM_LATENCY, 1, number of cycles (>=1) the request is held on the memory port; rdata is sampled on the last one.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  EXU has an op
- in_ready  output  1  LSU can accept (IDLE only)
- in_ren  input  1  op is a load
- in_wen  input  1  op is a store
- in_funct3  input  3  RV32 load/store funct3
- in_addr  input  32  effective byte address
- in_wdata  input  32  store data (rs2)
- out_valid  output  1  result ready for WBU
- out_ready  input  1  WBU accepts
- out_rdata  output  32  extended load data (0 for stores/errors)
- out_err  output  1  misaligned address or illegal funct3
- mem_valid  output  1  to memory valid
- mem_wen  output  1  to memory write enable
- mem_wmask  output  8  byte mask, bits [7:4] always 0
- mem_waddr  output  32  word address {addr[31:2],2'b00}
- mem_wdata  output  32  lane-shifted store data
- mem_raddr  output  32  same as mem_waddr
- mem_rdata  input  32  word read from memory

Behaviour:
- Reset: state IDLE, counter 0, all latched fields 0; in_ready=1, out_valid=0, out_rdata=0, out_err=0, all mem_* outputs 0.
- States IDLE, ACCESS, RESP (encodings in defines.v).
- IDLE: in_ready=1. On in_valid&&in_ready, latch ren, wen, funct3, addr, wdata; clear counter.
  - If in_wen=1, the op is a store and ren is ignored. Else if in_ren=1, it is a load. Else it is a no-op: go to RESP with rdata=0, err=0.
  - Error check: load funct3 not in {000,001,010,100,101}, store funct3 not in {000,001,010}, halfword with addr[0]=1, or word with addr[1:0]!=0 all set err=1. On error go to RESP with rdata=0; no memory access occurs.
  - Otherwise go to ACCESS.
- ACCESS: mem_valid=1 every cycle; address, mask and data held stable. The counter increments each cycle.
  - mem_wen=1 only on the final ACCESS cycle (counter==MEM_LATENCY-1), so each store writes exactly once.
  - On the final cycle, latch the extracted load data and go to RESP.
  - MEM_LATENCY=1 gives a single ACCESS cycle.
- Store mask and data, with off=addr[1:0]:
  - SB: wmask=8'h01<<off, wdata=wdata[7:0]<<(8*off)
  - SH: wmask=8'h03<<off, wdata=wdata[15:0]<<(8*off)
  - SW: wmask=8'h0F, wdata unshifted
  - Loads drive wmask=0, wdata=0.
- Load extraction: select byte/half at off from mem_rdata.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word.
- RESP: out_valid=1; out_rdata/out_err stay stable until out_ready. On out_valid&&out_ready go to IDLE; in_ready is 1 the next cycle, so there is no same-cycle re-accept.
- Outside ACCESS, all mem_* outputs are 0.
- Latency: accept edge, MEM_LATENCY ACCESS cycles, then out_valid. With back-to-back ready the minimum op period is MEM_LATENCY+2 cycles.
- Reset asserted in any state returns to IDLE immediately and drops mem_valid/mem_wen asynchronously. No partial write is reissued after reset.

Decomposition:
- defines.v (shared): funct3 constants (LB/LH/LW/LBU/LHU/SB/SH/SW), LSU state encodings, `RegBus width.
- Sub-module lsu_align, purely combinational: (funct3, off, wdata, mem_rdata) -> (wmask, shifted wdata, extended rdata, misalign). The FSM and counter stay in lsu.

Test Plan:
- SW addr=0x80000004 data=0xDEADBEEF, MEM_LATENCY=1 -> mem_waddr=0x80000004, wmask=0x0F, mem_wen high exactly 1 cycle, out_valid next cycle with out_rdata=0, err=0.
- SB addr=0x80000003 data=0x000000AB -> wmask=0x08, mem_wdata=0xAB000000, waddr=0x80000000. Then LB same addr with mem_rdata=0xAB000000 -> out_rdata=0xFFFFFFAB; LBU -> 0x000000AB.
- LH addr=0x80000002, mem_rdata=0x8001_1234 -> 0xFFFF8001; LHU -> 0x00008001.
- LW addr=0x80000002 -> out_err=1, out_rdata=0, mem_valid never asserted. Load funct3=011 -> out_err=1.
- MEM_LATENCY=3, SH addr=0x80000000: mem_valid high 3 cycles, mem_wen only on 3rd. Hold out_ready=0 for 4 cycles -> out_valid/out_rdata stable, in_ready=0 throughout.
- Assert rst during the 2nd ACCESS cycle of a MEM_LATENCY=3 store -> mem_valid/mem_wen drop immediately, no write occurs, in_ready=1, out_valid=0.
